// File: rtl/gbe_pkt_pkg.sv
// Shared types and helpers for the 10GbE tx packetizer.
package gbe_pkt_pkg;

   typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

   localparam logic [15:0] MAGIC_DEFAULT = 16'h5253;

   // Header layout: {magic, word index within spectrum, spectrum count}
   function automatic logic [63:0] build_hdr(input logic [15:0] magic,
                                             input logic [15:0] idx,
                                             input logic [31:0] spec);
      return {magic, idx, spec};
   endfunction

endpackage

// File: rtl/gbe_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO; o_dout always shows the head entry.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module gbe_pkt_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 512
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_rd    = i_pop && !o_empty;
   assign w_wr    = i_push && (!o_full || w_rd);
   assign o_dout  = r_mem[r_rptr];
   assign o_count = r_count;

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_din;
   end

   // Pointer and occupancy tracking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/gbe_tx_packetizer.sv
// Packs the 64-bit spectrometer stream into header + PAYLOAD_WORDS UDP payloads
// for the 10GbE core, honouring tx_afull backpressure.
module gbe_tx_packetizer
   import gbe_pkt_pkg::*;
#(
   parameter int          PAYLOAD_WORDS = 128,
   parameter int          FIFO_DEPTH    = 512,
   parameter logic [15:0] MAGIC         = MAGIC_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic        i_in_valid,
   input  logic [63:0] i_in_data,
   input  logic        i_in_sync,
   input  logic [31:0] i_dest_ip,
   input  logic [15:0] i_dest_port,
   input  logic        i_tx_afull,
   output logic        o_tx_valid,
   output logic [63:0] o_tx_data,
   output logic        o_tx_end_of_frame,
   output logic [31:0] o_tx_dest_ip,
   output logic [15:0] o_tx_dest_port,
   output logic [31:0] o_drop_cnt,
   output logic [31:0] o_pkt_cnt
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int PCW = $clog2(PAYLOAD_WORDS + 1);
   localparam logic [CW-1:0]  PW_C    = CW'(PAYLOAD_WORDS);
   localparam logic [PCW-1:0] PW_P    = PCW'(PAYLOAD_WORDS);
   localparam logic [PCW-1:0] PW_LAST = PCW'(PAYLOAD_WORDS - 1);

   state_t          r_state;
   logic [PCW-1:0]  r_pop_cnt;
   logic [31:0]     r_spec_cnt;
   logic [15:0]     r_word_idx;
   logic            r_tx_valid;
   logic [63:0]     r_tx_data;
   logic            r_tx_eof;
   logic [31:0]     r_tx_dest_ip;
   logic [15:0]     r_tx_dest_port;
   logic [31:0]     r_drop_cnt;
   logic [31:0]     r_pkt_cnt;

   logic [64:0]     w_head;
   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_start;
   logic            w_last;
   logic [63:0]     w_hdr;

   gbe_pkt_fifo #(.WIDTH(65), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_in_valid),
      .i_din   ({i_in_sync, i_in_data}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A whole payload must be buffered before the header goes out, so PAY never underflows
   assign w_start = (r_state == IDLE) && i_enable && (w_count >= PW_C) && !i_tx_afull;
   // The first payload word leaves on the edge that ends the header cycle
   assign w_pop   = !i_tx_afull && !w_empty && (r_pop_cnt != PW_P) &&
                    ((r_state == HDR) || (r_state == PAY));
   assign w_last  = (r_pop_cnt == PW_LAST);
   assign w_hdr   = w_head[64] ? build_hdr(MAGIC, 16'd0, r_spec_cnt + 32'd1)
                               : build_hdr(MAGIC, r_word_idx, r_spec_cnt);

   // Packet FSM with registered tx outputs; eof word is shown in PAY, then GAP idles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= IDLE;
         r_pop_cnt      <= '0;
         r_tx_valid     <= 1'b0;
         r_tx_data      <= '0;
         r_tx_eof       <= 1'b0;
         r_tx_dest_ip   <= '0;
         r_tx_dest_port <= '0;
         r_pkt_cnt      <= '0;
      end else begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_tx_eof   <= 1'b0;
         case (r_state)
            IDLE: if (w_start) begin
               r_state        <= HDR;
               r_tx_valid     <= 1'b1;
               r_tx_data      <= w_hdr;
               r_tx_dest_ip   <= i_dest_ip;
               r_tx_dest_port <= i_dest_port;
               r_pop_cnt      <= '0;
            end
            HDR, PAY: begin
               if (r_pop_cnt == PW_P) begin
                  r_state <= GAP;
               end else begin
                  r_state <= PAY;
                  if (w_pop) begin
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= w_head[63:0];
                     r_tx_eof   <= w_last;
                     r_pop_cnt  <= r_pop_cnt + 1'b1;
                     if (w_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
                  end
               end
            end
            GAP:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Spectrum position of the FIFO head, advanced on every payload pop
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_spec_cnt <= '0;
         r_word_idx <= '0;
      end else if (w_pop) begin
         if (w_head[64]) begin
            r_spec_cnt <= r_spec_cnt + 32'd1;
            r_word_idx <= 16'd1;
         end else begin
            r_word_idx <= r_word_idx + 16'd1;
         end
      end
   end

   // Saturating count of words lost to a full FIFO with no same-cycle pop
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_drop_cnt <= '0;
      else if (i_in_valid && w_full && !w_pop && (r_drop_cnt != '1))
         r_drop_cnt <= r_drop_cnt + 32'd1;
   end

   assign o_tx_valid        = r_tx_valid;
   assign o_tx_data         = r_tx_data;
   assign o_tx_end_of_frame = r_tx_eof;
   assign o_tx_dest_ip      = r_tx_dest_ip;
   assign o_tx_dest_port    = r_tx_dest_port;
   assign o_drop_cnt        = r_drop_cnt;
   assign o_pkt_cnt         = r_pkt_cnt;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// Directed bench for gbe_tx_packetizer (PAYLOAD_WORDS=4, FIFO_DEPTH=8).
module tb_gbe_tx_packetizer;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_in_valid = 1'b0;
   logic [63:0] i_in_data = '0;
   logic        i_in_sync = 1'b0;
   logic [31:0] i_dest_ip = '0;
   logic [15:0] i_dest_port = '0;
   logic        i_tx_afull = 1'b0;
   logic        o_tx_valid;
   logic [63:0] o_tx_data;
   logic        o_tx_end_of_frame;
   logic [31:0] o_tx_dest_ip;
   logic [15:0] o_tx_dest_port;
   logic [31:0] o_drop_cnt;
   logic [31:0] o_pkt_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int idle_bad = 0;

   logic [63:0] cap_d[$];
   bit          cap_e[$];
   logic [31:0] cap_ip[$];
   int          cap_c[$];

   gbe_tx_packetizer #(.PAYLOAD_WORDS(4), .FIFO_DEPTH(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
      .i_in_valid(i_in_valid), .i_in_data(i_in_data), .i_in_sync(i_in_sync),
      .i_dest_ip(i_dest_ip), .i_dest_port(i_dest_port), .i_tx_afull(i_tx_afull),
      .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
      .o_tx_end_of_frame(o_tx_end_of_frame), .o_tx_dest_ip(o_tx_dest_ip),
      .o_tx_dest_port(o_tx_dest_port), .o_drop_cnt(o_drop_cnt), .o_pkt_cnt(o_pkt_cnt)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Capture every tx word on the falling edge; idle cycles must be all-zero
   always @(negedge i_clk) begin
      if (o_tx_valid) begin
         cap_d.push_back(o_tx_data);
         cap_e.push_back(o_tx_end_of_frame);
         cap_ip.push_back(o_tx_dest_ip);
         cap_c.push_back(cyc);
      end else if (o_tx_data != '0 || o_tx_end_of_frame) begin
         idle_bad = idle_bad + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] qd(int i);
      return (i < cap_d.size()) ? cap_d[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction
   function automatic logic [63:0] qe(int i);
      return (i < cap_e.size()) ? 64'(cap_e[i]) : 64'hEE;
   endfunction
   function automatic logic [63:0] qip(int i);
      return (i < cap_ip.size()) ? 64'(cap_ip[i]) : 64'hDEAD;
   endfunction
   function automatic int qc(int i);
      return (i < cap_c.size()) ? cap_c[i] : -1000;
   endfunction
   function automatic int eof_sum();
      int s = 0;
      foreach (cap_e[k]) s += int'(cap_e[k]);
      return s;
   endfunction

   task automatic clr();
      cap_d.delete(); cap_e.delete(); cap_ip.delete(); cap_c.delete();
   endtask

   task automatic push(input logic [63:0] d, input logic s);
      i_in_valid = 1'b1; i_in_data = d; i_in_sync = s;
      @(posedge i_clk); #1;
      i_in_valid = 1'b0; i_in_data = '0; i_in_sync = 1'b0;
   endtask

   initial begin
      // reset state
      i_dest_ip = 32'hC0A8_0514;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_valid", o_tx_valid, 0);
      chk("rst_data", o_tx_data, 0);
      chk("rst_pkt", o_pkt_cnt, 0);
      chk("rst_drop", o_drop_cnt, 0);
      chk("rst_ip", o_tx_dest_ip, 0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // 1: two packets from 8 words, sync on the first
      i_enable = 1'b1;
      clr();
      for (int i = 0; i < 8; i++) push(64'hA0 + 64'(i), i == 0);
      repeat (20) @(posedge i_clk); #1;
      chk("t1_nwords", cap_d.size(), 10);
      chk("t1_hdr0", qd(0), 64'h5253_0000_0000_0001);
      chk("t1_hdr1", qd(5), 64'h5253_0004_0000_0001);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_p0w%0d", i), qd(1 + i), 64'hA0 + 64'(i));
         chk($sformatf("t1_p1w%0d", i), qd(6 + i), 64'hA4 + 64'(i));
      end
      chk("t1_eof0", qe(4), 1);
      chk("t1_eof1", qe(9), 1);
      chk("t1_eofn", eof_sum(), 2);
      chk("t1_period", qc(5) - qc(0), 7);
      chk("t1_pkt", o_pkt_cnt, 2);
      chk("t1_drop", o_drop_cnt, 0);

      // 2: tx_afull for 3 cycles in the middle of PAY
      clr();
      for (int i = 0; i < 4; i++) push(64'hB0 + 64'(i), 1'b0);
      @(posedge i_clk);             // header launched
      @(posedge i_clk);             // B0
      @(posedge i_clk); #1;         // B1
      i_tx_afull = 1'b1;
      repeat (3) @(posedge i_clk);
      #1 i_tx_afull = 1'b0;
      repeat (10) @(posedge i_clk); #1;
      chk("t2_nwords", cap_d.size(), 5);
      chk("t2_hdr", qd(0), 64'h5253_0008_0000_0001);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_w%0d", i), qd(1 + i), 64'hB0 + 64'(i));
      chk("t2_eof", qe(4), 1);
      chk("t2_eofn", eof_sum(), 1);
      chk("t2_b0b1", qc(2) - qc(1), 1);
      chk("t2_stall", qc(3) - qc(2), 4);
      chk("t2_pkt", o_pkt_cnt, 3);

      // 4: destination change mid-packet applies only to the next packet
      clr();
      i_dest_port = 16'h2710;
      for (int i = 0; i < 6; i++) push(64'hC0 + 64'(i), 1'b0);
      i_dest_ip = 32'hC0A8_0515;
      for (int i = 6; i < 8; i++) push(64'hC0 + 64'(i), 1'b0);
      repeat (15) @(posedge i_clk); #1;
      chk("t4_nwords", cap_d.size(), 10);
      chk("t4_hdr0", qd(0), 64'h5253_000C_0000_0001);
      chk("t4_hdr1", qd(5), 64'h5253_0010_0000_0001);
      chk("t4_ip_p0h", qip(0), 64'hC0A8_0514);
      chk("t4_ip_p0e", qip(4), 64'hC0A8_0514);
      chk("t4_ip_p1h", qip(5), 64'hC0A8_0515);
      chk("t4_ip_p1e", qip(9), 64'hC0A8_0515);
      chk("t4_port", o_tx_dest_port, 16'h2710);
      chk("t4_pkt", o_pkt_cnt, 5);

      // 5: enable dropped during PAY; packet completes, no new header
      clr();
      for (int i = 0; i < 6; i++) push(64'hD0 + 64'(i), 1'b0);
      i_enable = 1'b0;
      for (int i = 6; i < 8; i++) push(64'hD0 + 64'(i), 1'b0);
      repeat (20) @(posedge i_clk); #1;
      chk("t5_nwords", cap_d.size(), 5);
      chk("t5_last", qd(4), 64'hD3);
      chk("t5_eof", qe(4), 1);
      chk("t5_pkt", o_pkt_cnt, 6);
      chk("t5_fifo", dut.w_count, 4);

      // 6: asynchronous reset in the middle of PAY
      i_enable = 1'b1;
      repeat (3) @(posedge i_clk); #1;
      chk("t6_pre_valid", o_tx_valid, 1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t6_valid", o_tx_valid, 0);
      chk("t6_data", o_tx_data, 0);
      chk("t6_eof", o_tx_end_of_frame, 0);
      chk("t6_ip", o_tx_dest_ip, 0);
      chk("t6_port", o_tx_dest_port, 0);
      chk("t6_pkt", o_pkt_cnt, 0);
      chk("t6_fifo", dut.w_count, 0);
      chk("t6_spec", dut.r_spec_cnt, 0);
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      repeat (3) @(posedge i_clk); #1;
      chk("t6_post_fifo", dut.w_count, 0);
      chk("t6_post_spec", dut.r_spec_cnt, 0);
      chk("t6_post_valid", o_tx_valid, 0);

      // 3: overflow with output stalled
      clr();
      i_enable = 1'b0;
      i_tx_afull = 1'b1;
      for (int i = 0; i < 10; i++) push(64'hE0 + 64'(i), 1'b0);
      repeat (3) @(posedge i_clk); #1;
      chk("t3_drop", o_drop_cnt, 2);
      chk("t3_fifo", dut.w_count, 8);
      chk("t3_notx", cap_d.size(), 0);

      chk("idle_zero", idle_bad, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
